// File: rtl/seq_multiplier_if.sv
// Multiply handshake between the factorial controller (master) and the
// sequential multiplier (slave): operands plus start/clear out, product plus done back.
interface seq_multiplier_if #(
    parameter int WIDTH = 64
);
    logic                   op_start;
    logic                   op_clear;
    logic [WIDTH-1:0]       multiplier;
    logic [WIDTH-1:0]       multiplicand;
    logic [2*WIDTH-1:0]     result;
    logic                   op_done;

    modport master (
        output op_start, op_clear, multiplier, multiplicand,
        input  result, op_done
    );

    modport slave (
        input  op_start, op_clear, multiplier, multiplicand,
        output result, op_done
    );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per clock, fixed
// WIDTH-cycle latency, product held with op_done until op_clear or reset.
module seq_multiplier #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    seq_multiplier_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_m;
    logic [2*WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_result;
    logic                   r_done;

    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       w_m_nxt;
    logic [2*WIDTH-1:0]     w_b_nxt;
    logic [2*WIDTH-1:0]     w_acc_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [2*WIDTH-1:0]     w_result_nxt;
    logic                   w_done_nxt;
    logic [2*WIDTH-1:0]     w_acc_sum;

    // Partial sum including this cycle's conditional add; the product can
    // never exceed 2*WIDTH bits, so the wrap is never exercised.
    assign w_acc_sum = r_acc + (r_m[0] ? r_b : '0);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        w_state_nxt  = r_state;
        w_m_nxt      = r_m;
        w_b_nxt      = r_b;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_done_nxt   = r_done;

        if (bus.op_clear) begin
            w_state_nxt  = IDLE;
            w_m_nxt      = '0;
            w_b_nxt      = '0;
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
            w_result_nxt = '0;
            w_done_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.op_start) begin
                        w_m_nxt     = bus.multiplier;
                        w_b_nxt     = {{WIDTH{1'b0}}, bus.multiplicand};
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    w_acc_nxt = w_acc_sum;
                    w_b_nxt   = r_b << 1;
                    w_m_nxt   = r_m >> 1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        w_result_nxt = w_acc_sum;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = DONE;
                    end
                end
                DONE: begin
                    // Held until clear or reset; op_start is deliberately ignored here.
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_m      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_m      <= w_m_nxt;
            r_b      <= w_b_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.result  = r_result;
    assign bus.op_done = r_done;
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed scenarios plus random operands,
// compared against a plain-arithmetic product and a fixed-latency expectation.
module tb_seq_multiplier;
    localparam int WIDTH = 64;
    localparam int CNT_W = 7;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

    seq_multiplier #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*WIDTH-1:0] obs,
                         input logic [2*WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [2*WIDTH-1:0] model_product(input logic [WIDTH-1:0] a,
                                                         input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] wa;
        logic [2*WIDTH-1:0] wb;
        wa = {{WIDTH{1'b0}}, a};
        wb = {{WIDTH{1'b0}}, b};
        return wa * wb;
    endfunction

    // Called at a negedge with op_start high and the DUT idle; counts edges
    // until op_done is seen (accept edge counts as 1), optionally scrambling operands.
    task automatic wait_done(input bit scramble, input string tag, output int cycles);
        logic [2*WIDTH-1:0] first_res;
        bit                 partial;
        first_res = bus.result;
        partial   = 1'b0;
        cycles    = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (scramble) begin
                bus.multiplier   = {$urandom, $urandom};
                bus.multiplicand = {$urandom, $urandom};
            end
            if (bus.op_done === 1'b1) begin
                cycles = i;
                break;
            end
            if (bus.result !== first_res) partial = 1'b1;
        end
        check({tag, "_no_partial"}, {127'b0, partial}, '0);
    endtask

    // Clear for one cycle with start held high, then expect a restart next edge.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit scramble, input string tag);
        int                 cyc;
        logic [2*WIDTH-1:0] exp;
        exp              = model_product(a, b);
        bus.op_clear     = 1'b1;
        bus.op_start     = 1'b1;
        bus.multiplier   = a;
        bus.multiplicand = b;
        @(negedge clk);
        check({tag, "_clr_done"}, {127'b0, bus.op_done}, '0);
        check({tag, "_clr_result"}, bus.result, '0);
        bus.op_clear = 1'b0;
        wait_done(scramble, tag, cyc);
        check({tag, "_latency"}, (2*WIDTH)'(cyc), (2*WIDTH)'(WIDTH + 1));
        check({tag, "_result"}, bus.result, exp);
        repeat (3) @(negedge clk);
        check({tag, "_hold_done"}, {127'b0, bus.op_done}, {127'b0, 1'b1});
        check({tag, "_hold_result"}, bus.result, exp);
    endtask

    initial begin
        int                 cyc;
        logic [WIDTH-1:0]   ra;
        logic [WIDTH-1:0]   rb;
        n_checks = 0;
        n_pass   = 0;

        // Reset held with start high and operands 5x10 present.
        reset_n          = 1'b0;
        bus.op_clear     = 1'b0;
        bus.op_start     = 1'b1;
        bus.multiplier   = 64'd5;
        bus.multiplicand = 64'd10;
        repeat (3) @(negedge clk);
        check("reset_done", {127'b0, bus.op_done}, '0);
        check("reset_result", bus.result, '0);

        reset_n = 1'b1;
        wait_done(1'b0, "t1", cyc);
        check("t1_latency", (2*WIDTH)'(cyc), (2*WIDTH)'(WIDTH + 1));
        check("t1_result", bus.result, model_product(64'd5, 64'd10));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t1_hold_done", {127'b0, bus.op_done}, {127'b0, 1'b1});
            check("t1_hold_result", bus.result, model_product(64'd5, 64'd10));
        end

        do_op('1, '1, 1'b0, "t2_max");
        do_op('0, 64'hDEAD_BEEF, 1'b0, "t3_zero");

        // Abort 7x9 at BUSY cycle 30, then restart 3x4 with start still high.
        bus.op_clear     = 1'b1;
        bus.op_start     = 1'b1;
        bus.multiplier   = 64'd7;
        bus.multiplicand = 64'd9;
        @(negedge clk);
        bus.op_clear = 1'b0;
        repeat (30) @(negedge clk);
        check("t4_mid_done", {127'b0, bus.op_done}, '0);
        check("t4_mid_result", bus.result, '0);
        do_op(64'd3, 64'd4, 1'b0, "t4_restart");

        // Reset with simultaneous clear in the middle of 6x7.
        bus.op_clear     = 1'b1;
        bus.multiplier   = 64'd6;
        bus.multiplicand = 64'd7;
        @(negedge clk);
        bus.op_clear = 1'b0;
        repeat (10) @(negedge clk);
        reset_n      = 1'b0;
        bus.op_clear = 1'b1;
        @(negedge clk);
        check("t5_rst_done", {127'b0, bus.op_done}, '0);
        check("t5_rst_result", bus.result, '0);
        bus.op_clear = 1'b0;
        bus.op_start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_idle_done", {127'b0, bus.op_done}, '0);
        bus.op_start     = 1'b1;
        bus.multiplier   = 64'd6;
        bus.multiplicand = 64'd7;
        wait_done(1'b1, "t5_scramble", cyc);
        check("t5_latency", (2*WIDTH)'(cyc), (2*WIDTH)'(WIDTH + 1));
        check("t5_result", bus.result, model_product(64'd6, 64'd7));

        do_op(64'd4, 64'd50, 1'b0, "t6_chain");
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("t6_no_retrigger", bus.result, model_product(64'd4, 64'd50));

        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, "msb_only");

        for (int n = 0; n < 6; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n == 0) ra = ra >> 40;
            do_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Sequential unsigned shift-add multiplier. It is the responder side of the factorial controller's multiply handshake. The controller drives operands plus start/clear, and this block returns a double-width product with a done flag. Radix-2: one multiplier bit per clock, fixed latency, one operation in flight.

Parameters:
WIDTH, 64, operand width in bits; product is 2*WIDTH bits.
CNT_W, 7, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset_n  input  1  reset; synchronous, active-low.
op_start  input  1  level request; sampled only in IDLE.
op_clear  input  1  level; aborts any operation, returns to IDLE, zeroes outputs.
multiplier  input  WIDTH  operand A; captured on accepted start.
multiplicand  input  WIDTH  operand B; captured on accepted start.
result  output  2*WIDTH  product; valid when op_done=1.
op_done  output  1  high while a completed product is held.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, result=0, op_done=0, counter=0, internal accumulator/operand registers=0. Reset beats op_clear and op_start, including mid-operation.
- States: IDLE, BUSY, DONE. 2-bit encoding; unused encoding goes to IDLE.
- Priority at each edge: reset_n=0, then op_clear=1, then state action.
- op_clear=1 in any state: next state IDLE, result=0, op_done=0, counter=0. Any partial product is discarded.
- IDLE: op_start=1 at edge t0 latches multiplier into shift register M and multiplicand into B (zero-extended to 2*WIDTH). It also sets acc=0, counter=0, state=BUSY. op_start=0: stay IDLE, outputs unchanged.
- BUSY, each edge:
  - if M[0]=1, acc <= acc + B, performed mod 2^(2*WIDTH); overflow is impossible.
  - B <<= 1, M >>= 1, counter += 1.
  - On the edge where counter==WIDTH-1: result <= final acc including this step's add, op_done <= 1, state=DONE.
  - op_start and operand inputs are ignored in BUSY; operand changes do not affect the running operation.
- Latency: start accepted at edge t0, then op_done=1 and result valid after edge t0+WIDTH (64 cycles at default). No early termination for zero or small operands; latency is fixed.
- DONE: result and op_done held indefinitely. op_start is ignored, including when held continuously high. Only op_clear or reset leaves DONE.
- After clear to IDLE, if op_start is still high, a new operation is accepted at the next edge. A level-held start therefore gives a clear-to-restart turnaround of 1 cycle.
- result changes only on reset, clear, or the DONE-entry edge; it never shows partial products.
- op_done never pulses for a single cycle unless clear arrives on the cycle after DONE entry.

Test Plan:
1. Reset with op_start=1, multiplier=5, multiplicand=10. Release reset_n at edge t0 → BUSY starts at edge t0+1. At edge t0+65: op_done=1, result=50. Result stays 50 for 20 more cycles with op_start still high.
2. multiplier=multiplicand=2^64-1 → after 64 BUSY cycles, result=0xFFFFFFFFFFFFFFFE0000000000000001, op_done=1.
3. Zero operand: multiplier=0, multiplicand=0xDEADBEEF → op_done rises after exactly 64 cycles, result=0.
4. Clear mid-operation: start 7x9, assert op_clear for 1 cycle at BUSY cycle 30 → op_done=0, result=0 next edge. With op_start still high, a restart with new operands 3x4 gives result=12 exactly 64 cycles after acceptance.
5. Reset mid-BUSY with op_clear=1 simultaneously → all outputs 0, state IDLE. Change operands during BUSY (start 6x7, then alter inputs) → result=42, unaffected.
6. Chained use: clear, then start 4x(prior result 50) → 200. op_start held high throughout never re-triggers while in DONE.
